// File: rtl/plab4_net_demux_buf_pkg.sv
// Shared plab4-net constants and helpers for the per-domain demux buffer.
// Supplies the default message widths, queue sizing and the drop counter.
package plab4_net_demux_buf_pkg;

   localparam int c_msg_cnbits    = 32;
   localparam int c_msg_dnbits    = 32;
   localparam int c_num_domains   = 2;
   localparam int c_depth         = 2;
   localparam int c_drop_cnt_bits = 8;

   typedef logic [c_drop_cnt_bits-1:0] drop_cnt_t;

   localparam drop_cnt_t c_drop_cnt_max = 8'd255;

   // Domain select width: never narrower than one bit.
   function automatic int dom_bits(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
      return (v == c_drop_cnt_max) ? v : v + drop_cnt_t'(1);
   endfunction

endpackage

// File: rtl/plab4_net_demux_queue.sv
// Single-domain FIFO with wrap-bit pointers; the head is forced to zero when
// empty so an idle domain never exposes stale storage.
module plab4_net_demux_queue #(
   parameter int p_width = 64,
   parameter int p_depth = 2
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               enq_val,
   input  logic [p_width-1:0] enq_msg,
   output logic               full,
   input  logic               deq_rdy,
   output logic               deq_val,
   output logic [p_width-1:0] deq_msg
);

   localparam int c_aw = $clog2(p_depth);

   logic [c_aw:0]        wr_ptr_q, wr_ptr_d;
   logic [c_aw:0]        rd_ptr_q, rd_ptr_d;
   logic [p_width-1:0]   mem_q [p_depth];
   logic                 full_s, empty_s, enq_fire_s, deq_fire_s;
   logic [p_width-1:0]   deq_msg_s;

   // Occupancy flags, pointer advance and gated head read.
   always_comb begin
      empty_s    = (wr_ptr_q == rd_ptr_q);
      full_s     = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                   (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
      enq_fire_s = enq_val & ~full_s;
      deq_fire_s = deq_rdy & ~empty_s;
      wr_ptr_d   = enq_fire_s ? (wr_ptr_q + (c_aw+1)'(1)) : wr_ptr_q;
      rd_ptr_d   = deq_fire_s ? (rd_ptr_q + (c_aw+1)'(1)) : rd_ptr_q;
      deq_msg_s  = empty_s ? {p_width{1'b0}} : mem_q[rd_ptr_q[c_aw-1:0]];
   end

   // Pointer registers; reset empties the queue without touching storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= {(c_aw+1){1'b0}};
         rd_ptr_q <= {(c_aw+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage write.
   always_ff @(posedge clk) begin
      if (enq_fire_s) begin
         mem_q[wr_ptr_q[c_aw-1:0]] <= enq_msg;
      end
   end

   assign full    = full_s;
   assign deq_val = ~empty_s;
   assign deq_msg = deq_msg_s;

endmodule

// File: rtl/plab4_net_demux_buf.sv
// Demultiplexes one input stream into per-security-domain FIFOs; messages for
// a non-existent domain are swallowed and counted.
module plab4_net_demux_buf
   import plab4_net_demux_buf_pkg::*;
#(
   parameter  int p_msg_cnbits  = c_msg_cnbits,
   parameter  int p_msg_dnbits  = c_msg_dnbits,
   parameter  int p_num_domains = c_num_domains,
   parameter  int p_depth       = c_depth,
   localparam int c_dw          = dom_bits(p_num_domains)
)(
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [c_dw-1:0]                       domain,
   input  logic                                  in_val,
   output logic                                  in_rdy,
   input  logic [p_msg_cnbits-1:0]               in_msg_control,
   input  logic [p_msg_dnbits-1:0]               in_msg_data,
   output logic [p_num_domains-1:0]              out_val,
   input  logic [p_num_domains-1:0]              out_rdy,
   output logic [p_num_domains*p_msg_cnbits-1:0] out_msg_control,
   output logic [p_num_domains*p_msg_dnbits-1:0] out_msg_data,
   output logic [c_drop_cnt_bits-1:0]            drop_count
);

   localparam int             c_qw      = p_msg_cnbits + p_msg_dnbits;
   localparam logic [c_dw:0]  c_num_dom = (c_dw+1)'(p_num_domains);

   logic [p_num_domains-1:0] sel_s, full_s, enq_s;
   logic                     in_range_s, rdy_sel_s, in_rdy_s, drop_s;
   drop_cnt_t                drop_count_q, drop_count_d;

   // Domain decode, ready selection and drop detection. Ready never looks at
   // out_rdy, so a full queue stays closed even while it is draining.
   always_comb begin
      sel_s = {p_num_domains{1'b0}};
      for (int d = 0; d < p_num_domains; d++) begin
         sel_s[d] = (domain == c_dw'(d));
      end
      in_range_s   = ({1'b0, domain} < c_num_dom);
      rdy_sel_s    = in_range_s ? ~|(full_s & sel_s) : 1'b1;
      in_rdy_s     = reset & rdy_sel_s;
      enq_s        = (in_val & in_rdy_s & in_range_s) ? sel_s : {p_num_domains{1'b0}};
      drop_s       = in_val & in_rdy_s & ~in_range_s;
      drop_count_d = drop_s ? sat_inc(drop_count_q) : drop_count_q;
   end

   // Saturating count of discarded messages.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_count_q <= {c_drop_cnt_bits{1'b0}};
      end else begin
         drop_count_q <= drop_count_d;
      end
   end

   for (genvar g = 0; g < p_num_domains; g++) begin : g_dom
      logic [c_qw-1:0] head_msg_s;

      plab4_net_demux_queue #(
         .p_width (c_qw),
         .p_depth (p_depth)
      ) u_queue (
         .clk     (clk),
         .reset   (reset),
         .enq_val (enq_s[g]),
         .enq_msg ({in_msg_control, in_msg_data}),
         .full    (full_s[g]),
         .deq_rdy (out_rdy[g]),
         .deq_val (out_val[g]),
         .deq_msg (head_msg_s)
      );

      assign out_msg_control[g*p_msg_cnbits +: p_msg_cnbits] = head_msg_s[p_msg_dnbits +: p_msg_cnbits];
      assign out_msg_data[g*p_msg_dnbits +: p_msg_dnbits]    = head_msg_s[0 +: p_msg_dnbits];
   end

   assign in_rdy     = in_rdy_s;
   assign drop_count = drop_count_q;

endmodule
